laser_dual_receiver: RTL and testbench
======================================

Name: laser_dual_receiver

Overview:
- Receive end of the two-lane laser link: recovers one byte per lane per frame from the photodiode inputs and presents the two bytes as an aligned pair.
- Frame on each lane: start bit 0, 8 data bits LSB first, stop bit 1; idle line is 1; both lanes are sent in parallel with a common bit period.
- Sits between the photodiode input pins and the host-side packet buffer; a pair is delivered only when both lanes framed cleanly.

Parameters:
- CLKS_PER_BIT, 8, clocks per bit period; must be even and ≥4.
- SYNC_STAGES, 2, depth of the input synchronizer per lane; must be ≥2.
- SKEW_MAX, 4, maximum clocks between the two lane completions for them to be paired.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- laser1_in  input  1  lane 1 photodiode, asynchronous to clock
- laser2_in  input  1  lane 2 photodiode, asynchronous to clock
- data1_out  output  8  lane 1 byte, valid with data_valid
- data2_out  output  8  lane 2 byte, valid with data_valid
- data_valid  output  1  one-cycle pulse: pair available
- frame_error  output  1  one-cycle pulse: either lane's stop bit sampled 0
- skew_error  output  1  one-cycle pulse: one lane finished, the other did not within SKEW_MAX

Behaviour:
- Reset: all outputs 0; lane FSMs IDLE; synchronizer flops 0; edge-detect "previous" flop 0. A line stuck low after reset therefore never starts a frame; it must be seen high first.
- Per-lane FSM states:
  - IDLE: wait for a synced 1→0 edge, then go to START with the counter cleared.
  - START: sample when count == CLKS_PER_BIT/2−1. If the sample is 0, go to DATA with the counter cleared. If it is 1, treat it as a glitch and return to IDLE silently.
  - DATA: sample when count == CLKS_PER_BIT−1, shift right with the sample into bit 7, clear the counter. After the 8th sample go to STOP.
  - STOP: sample at count == CLKS_PER_BIT−1. A 1 gives a lane_done pulse; a 0 gives a lane_err pulse. Return to IDLE in both cases.
- Pairing stage (top level):
  - Each lane_done latches that lane's byte and sets a pending flag.
  - When both flags are set, including when both lanes finish in the same cycle: data_valid = 1 for one cycle, the latched bytes are driven onto data1/2_out on the next clock, and the flags clear.
  - data1/2_out hold their value until the next data_valid.
  - With exactly one flag pending, a skew counter runs. On reaching SKEW_MAX: skew_error pulses for one cycle, the pending byte is dropped, and the flag clears.
  - Either lane_err: frame_error pulses for one cycle and both pending flags clear (the whole pair is dropped). A lane_err on the pending lane itself also clears that flag. If lane_err and lane_done arrive together, the error wins and data_valid stays low.
- Latency: let t0 be the clock edge on which synchronizer stage 1 first captures the start-bit 0. data_valid is high in the cycle after edge t0 + SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1, which is edge t0+79 at defaults.
- Back-to-back frames: a start bit immediately after the stop sample is accepted; no idle gap is required beyond the remaining half of the stop bit.
- Reset mid-frame: immediate abort. No pulse is emitted and the partial byte is discarded.
- Counter widths: $clog2(CLKS_PER_BIT) bits and $clog2(SKEW_MAX+1) bits; no wrap is reachable.

Decomposition:
- Shared package laser_pkg holds:
  - typedef enum lane_state_t {IDLE, START, DATA, STOP};
  - constants FRAME_DATA_BITS = 8, LINE_IDLE = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1.
- Sub-module laser_lane_rx, instantiated twice: synchronizer, edge detect, lane FSM, bit counter and shift register. It outputs byte[7:0], lane_done and lane_err.
- The top level contains only the pairing/skew logic.

Test Plan:
- Clean pair: frames 0xA5 on lane 1 and 0x3C on lane 2, both aligned → one data_valid pulse at t0+79; data1_out=0xA5, data2_out=0x3C; no error pulses.
- Lane skew within limit: lane 2 delayed by 3 clocks, bytes 0x01/0xFF → data_valid 3 cycles later than the aligned case; bytes correct.
- Skew beyond limit: lane 2 delayed by 6 clocks → skew_error pulses once after lane 1 completes plus 4 clocks. Lane 2 then ends up pending and also produces a skew_error. No data_valid.
- Bad stop bit: lane 1 stop bit driven 0, byte 0x55 → single frame_error pulse, no data_valid. With lane 1 held low 20 bit periods afterwards, no new frame is accepted until the line returns high and falls again.
- Glitch rejection: lane 1 low for 2 clocks while idle → FSM returns to IDLE, no pulses. A following valid pair 0x12/0x34 is received correctly.
- Reset mid-DATA: assert reset during bit 4 → all outputs 0 and no pulses. The next clean pair 0x80/0x7F is received with standard latency.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and framing constants for the two-lane laser link receiver.
package laser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } lane_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/laser_dual_receiver_if.sv
// Bus between the photodiode pins, the receiver and the host-side packet buffer.
interface laser_dual_receiver_if;

  logic       laser1_in;
  logic       laser2_in;
  logic [7:0] data1_out;
  logic [7:0] data2_out;
  logic       data_valid;
  logic       frame_error;
  logic       skew_error;

  // Receiver side: consumes the photodiode lines, produces the paired bytes.
  modport master (
    input  laser1_in,
    input  laser2_in,
    output data1_out,
    output data2_out,
    output data_valid,
    output frame_error,
    output skew_error
  );

  // Environment side: drives the lines, consumes the pairs.
  modport slave (
    output laser1_in,
    output laser2_in,
    input  data1_out,
    input  data2_out,
    input  data_valid,
    input  frame_error,
    input  skew_error
  );

endinterface

// File: rtl/laser_lane_rx.sv
// One lane of the laser link: synchronizer, falling-edge detect, frame FSM,
// bit-period counter and LSB-first shift register.
module laser_lane_rx
  import laser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_in,
  output logic [7:0] byte_out,
  output logic       lane_done,
  output logic       lane_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  lane_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Next-state logic for the synchronizer, edge detector and frame FSM.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], line_in};
    prev_d  = synced;
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Previous flop resets to 0, so a line must be seen high before it can start a frame.
        cnt_d = '0;
        if (prev_q && !synced) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = (synced == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {synced, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          done_d  = (synced == STOP_BIT);
          err_d   = (synced != STOP_BIT);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and registered pulses; reset aborts any frame in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Data shift register; only meaningful when lane_done pulses.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign byte_out  = shift_q;
  assign lane_done = done_q;
  assign lane_err  = err_q;

endmodule

// File: rtl/laser_dual_receiver.sv
// Two-lane laser link receiver: per-lane deframing plus pairing of the two
// bytes, with skew timeout and frame-error handling.
module laser_dual_receiver
  import laser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int SKEW_MAX     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  laser_dual_receiver_if.master bus
);

  localparam int SK_W = $clog2(SKEW_MAX + 1);
  localparam logic [SK_W-1:0] SKEW_LAST = SK_W'(SKEW_MAX - 1);

  logic [7:0]      byte1, byte2;
  logic            done1, done2, err1, err2;
  logic            pend1_q, pend1_d, pend2_q, pend2_d;
  logic [7:0]      hold1_q, hold1_d, hold2_q, hold2_d;
  logic [SK_W-1:0] skew_q, skew_d;
  logic [7:0]      data1_q, data1_d, data2_q, data2_d;
  logic            valid_q, valid_d, ferr_q, ferr_d, serr_q, serr_d;
  logic            have1, have2;

  laser_lane_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .SYNC_STAGES(SYNC_STAGES)) u_lane1 (
    .clock     (clock),
    .reset     (reset),
    .line_in   (bus.laser1_in),
    .byte_out  (byte1),
    .lane_done (done1),
    .lane_err  (err1)
  );

  laser_lane_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .SYNC_STAGES(SYNC_STAGES)) u_lane2 (
    .clock     (clock),
    .reset     (reset),
    .line_in   (bus.laser2_in),
    .byte_out  (byte2),
    .lane_done (done2),
    .lane_err  (err2)
  );

  assign have1 = pend1_q | done1;
  assign have2 = pend2_q | done2;

  // Pairing decision: errors first, then a complete pair, then skew timing.
  always_comb begin
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    skew_d  = skew_q;
    data1_d = data1_q;
    data2_d = data2_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    serr_d  = 1'b0;
    if (err1 || err2) begin
      // Any bad stop bit drops the whole pair, including a byte already waiting.
      ferr_d  = 1'b1;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
      skew_d  = '0;
    end else if (have1 && have2) begin
      // Bypass the hold registers so lanes finishing together pair immediately.
      valid_d = 1'b1;
      data1_d = done1 ? byte1 : hold1_q;
      data2_d = done2 ? byte2 : hold2_q;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
      skew_d  = '0;
    end else if (have1 || have2) begin
      if (done1) begin
        pend1_d = 1'b1;
        hold1_d = byte1;
      end
      if (done2) begin
        pend2_d = 1'b1;
        hold2_d = byte2;
      end
      if (pend1_q || pend2_q) begin
        if (skew_q == SKEW_LAST) begin
          serr_d  = 1'b1;
          pend1_d = 1'b0;
          pend2_d = 1'b0;
          skew_d  = '0;
        end else begin
          skew_d = skew_q + 1'b1;
        end
      end else begin
        skew_d = '0;
      end
    end
  end

  // Pending flags, skew counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      skew_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      skew_q  <= skew_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      serr_q  <= serr_d;
    end
  end

  // Byte holding registers for a lane waiting on its partner.
  always_ff @(posedge clock) begin
    hold1_q <= hold1_d;
    hold2_q <= hold2_d;
  end

  assign bus.data1_out   = data1_q;
  assign bus.data2_out   = data2_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.skew_error  = serr_q;

endmodule

// File: tb/tb_laser_dual_receiver.sv
// Bench for laser_dual_receiver: table of frame pairs plus hand-written
// corner sequences, checked through expectation queues.
module tb_laser_dual_receiver;
  import laser_pkg::*;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  localparam int SKEW = 4;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  laser_dual_receiver_if ifc ();

  laser_dual_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC), .SKEW_MAX(SKEW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.master)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d1;
    logic [7:0] d2;
  } pair_t;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    int         d2;
    logic       s1;
    logic       s2;
    bit         exp_dv;
    bit         exp_fe;
    int         lat;
  } vec_t;

  pair_t dv_q[$];
  int    fe_q[$];
  int    se_q[$];

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic check_reset_outputs();
    check_int("rst data1_out", ifc.data1_out, 0);
    check_int("rst data2_out", ifc.data2_out, 0);
    check_int("rst data_valid", ifc.data_valid, 0);
    check_int("rst frame_error", ifc.frame_error, 0);
    check_int("rst skew_error", ifc.skew_error, 0);
  endtask

  task automatic check_empty(input string tag);
    check_int({tag, " missing data_valid"}, dv_q.size(), 0);
    check_int({tag, " missing frame_error"}, fe_q.size(), 0);
    check_int({tag, " missing skew_error"}, se_q.size(), 0);
    dv_q.delete();
    fe_q.delete();
    se_q.delete();
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Starts right after a clock edge; the first line level is captured on the next edge (t0).
  task automatic drive_pair(input logic [7:0] b1, input logic [7:0] b2, input int d2,
                            input logic s1, input logic s2, input int hold1, input int abort_at);
    logic [9:0] f1, f2;
    int c2;
    f1 = {s1, b1, START_BIT};
    f2 = {s2, b2, START_BIT};
    for (int c = 0; c < 10 * CPB + d2 + hold1; c++) begin
      if (c == abort_at) begin
        ifc.laser1_in = LINE_IDLE;
        ifc.laser2_in = LINE_IDLE;
        reset = 1'b1;
        idle_wait(3);
        check_reset_outputs();
        reset = 1'b0;
        return;
      end
      if (c < 10 * CPB) ifc.laser1_in = f1[c / CPB];
      else if (c < 10 * CPB + hold1) ifc.laser1_in = 1'b0;
      else ifc.laser1_in = LINE_IDLE;
      c2 = c - d2;
      ifc.laser2_in = (c2 >= 0 && c2 < 10 * CPB) ? f2[c2 / CPB] : LINE_IDLE;
      idle_wait(1);
    end
    ifc.laser1_in = LINE_IDLE;
    ifc.laser2_in = LINE_IDLE;
  endtask

  // Output monitor: every pulse must match the oldest expectation of its kind.
  always @(negedge clock) begin
    if (!reset) begin
      if (ifc.data_valid) begin
        if (dv_q.size() == 0) check_int("unexpected data_valid", 1, 0);
        else begin
          pair_t e;
          e = dv_q.pop_front();
          check_int("data_valid cycle", cyc, e.cyc);
          check_int("data1_out", ifc.data1_out, e.d1);
          check_int("data2_out", ifc.data2_out, e.d2);
        end
      end
      if (ifc.frame_error) begin
        if (fe_q.size() == 0) check_int("unexpected frame_error", 1, 0);
        else check_int("frame_error cycle", cyc, fe_q.pop_front());
      end
      if (ifc.skew_error) begin
        if (se_q.size() == 0) check_int("unexpected skew_error", 1, 0);
        else check_int("skew_error cycle", cyc, se_q.pop_front());
      end
    end
  end

  initial begin
    vec_t vecs[7];
    pair_t p;
    int k;
    // Latencies are from the drive start k: t0 = k+1, data_valid seen after edge t0+79 = k+80.
    vecs[0] = '{8'hA5, 8'h3C, 0, 1'b1, 1'b1, 1'b1, 1'b0, 80};
    vecs[1] = '{8'h01, 8'hFF, 3, 1'b1, 1'b1, 1'b1, 1'b0, 83};
    vecs[2] = '{8'hFF, 8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0, 80};
    vecs[3] = '{8'hC3, 8'h5A, 4, 1'b1, 1'b1, 1'b1, 1'b0, 84};
    vecs[4] = '{8'h55, 8'h66, 0, 1'b0, 1'b1, 1'b0, 1'b1, 80};
    vecs[5] = '{8'h12, 8'h34, 2, 1'b1, 1'b0, 1'b0, 1'b1, 82};
    vecs[6] = '{8'h00, 8'h81, 1, 1'b1, 1'b1, 1'b1, 1'b0, 81};

    reset = 1'b1;
    ifc.laser1_in = LINE_IDLE;
    ifc.laser2_in = LINE_IDLE;
    idle_wait(3);
    check_reset_outputs();
    reset = 1'b0;
    idle_wait(20);

    for (int i = 0; i < 7; i++) begin
      k = cyc;
      if (vecs[i].exp_dv) begin
        p = '{k + vecs[i].lat, vecs[i].b1, vecs[i].b2};
        dv_q.push_back(p);
      end
      if (vecs[i].exp_fe) fe_q.push_back(k + vecs[i].lat);
      drive_pair(vecs[i].b1, vecs[i].b2, vecs[i].d2, vecs[i].s1, vecs[i].s2, 0, -1);
      idle_wait(30);
      check_empty("vector");
    end

    // Skew of 6: lane 1 times out 5 edges after its done pulse, then lane 2 does the same.
    k = cyc;
    se_q.push_back(k + 84);
    se_q.push_back(k + 90);
    drive_pair(8'hAA, 8'h55, 6, 1'b1, 1'b1, 0, -1);
    idle_wait(30);
    check_empty("skew6");

    // Bad stop bit, then lane 1 held low for 20 bit periods: no new frame.
    k = cyc;
    fe_q.push_back(k + 80);
    drive_pair(8'h55, 8'h66, 0, 1'b0, 1'b1, 20 * CPB, -1);
    idle_wait(30);
    check_empty("stuck low");
    k = cyc;
    p = '{k + 80, 8'h9E, 8'h1B};
    dv_q.push_back(p);
    drive_pair(8'h9E, 8'h1B, 0, 1'b1, 1'b1, 0, -1);
    idle_wait(30);
    check_empty("after stuck");

    // Two-clock glitch while idle, then a clean pair.
    ifc.laser1_in = 1'b0;
    idle_wait(2);
    ifc.laser1_in = LINE_IDLE;
    idle_wait(40);
    check_empty("glitch");
    k = cyc;
    p = '{k + 80, 8'h12, 8'h34};
    dv_q.push_back(p);
    drive_pair(8'h12, 8'h34, 0, 1'b1, 1'b1, 0, -1);
    idle_wait(30);
    check_empty("after glitch");

    // Reset during data bit 4 (frame bit index 5), then a clean pair.
    drive_pair(8'hF0, 8'h0F, 0, 1'b1, 1'b1, 0, 5 * CPB + 3);
    idle_wait(20);
    check_empty("reset abort");
    k = cyc;
    p = '{k + 80, 8'h80, 8'h7F};
    dv_q.push_back(p);
    drive_pair(8'h80, 8'h7F, 0, 1'b1, 1'b1, 0, -1);
    idle_wait(30);
    check_empty("after reset");

    // Back-to-back frames with no idle gap after the stop bit.
    k = cyc;
    p = '{k + 80, 8'h5A, 8'hC3};
    dv_q.push_back(p);
    drive_pair(8'h5A, 8'hC3, 0, 1'b1, 1'b1, 0, -1);
    k = cyc;
    p = '{k + 80, 8'h96, 8'h69};
    dv_q.push_back(p);
    drive_pair(8'h96, 8'h69, 0, 1'b1, 1'b1, 0, -1);
    idle_wait(30);
    check_empty("back to back");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
